// File: rtl/gpr_pkg.sv
// Shared types and constants for the general-purpose register file write path.
package gpr_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } gpr_wr_t;

endpackage

// File: rtl/gpr_fwd_match.sv
// Youngest-first lookup of one register address against the pending write entries.
module gpr_fwd_match
    import gpr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  gpr_wr_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]    valid,
    input  logic [PTR_W-1:0]    tail,
    input  logic [REG_W-1:0]    addr,
    output logic                hit,
    output logic [DATA_W-1:0]   data
);

    logic [PTR_W-1:0] idx_s;
    logic             match_s;

    // Walk oldest to youngest so the last match (nearest the tail) wins.
    always_comb begin
        hit     = 1'b0;
        data    = '0;
        idx_s   = '0;
        match_s = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx_s   = tail - PTR_W'(k);
            match_s = valid[idx_s] && (entries[idx_s].addr == addr) && (addr != REG_ZERO);
            hit     = hit | match_s;
            data    = match_s ? entries[idx_s].data : data;
        end
    end

endmodule

// File: rtl/gpr_write_queue.sv
// In-order write queue in front of the register file write port, with
// forwarding of the youngest pending value to the Rs/Rt read lookups.
module gpr_write_queue
    import gpr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    WrValid,
    output logic                    WrReady,
    input  logic [4:0]              WrAddr,
    input  logic [31:0]             WrData,
    input  logic                    Stall,
    output logic                    RegWrite,
    output logic [4:0]              RegAddr,
    output logic [31:0]             RegData,
    input  logic [4:0]              Rs,
    input  logic [4:0]              Rt,
    output logic                    RsHit,
    output logic                    RtHit,
    output logic [31:0]             RsFwd,
    output logic [31:0]             RtFwd,
    output logic [$clog2(DEPTH):0]  Count,
    output logic                    Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    gpr_wr_t [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    count_r;

    logic                full_s;
    logic                empty_s;
    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic [DEPTH-1:0]    valid_s;
    logic [PTR_W-1:0]    offset_s;

    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign empty_s  = (count_r == CNT_W'(0));
    // Reset is folded in so the producer never sees ready while the queue is held.
    assign WrReady  = reset & ~full_s;
    assign accept_s = WrValid & WrReady;
    assign push_s   = accept_s & (WrAddr != REG_ZERO);
    assign pop_s    = ~empty_s & ~Stall;

    assign RegWrite = pop_s;
    assign RegAddr  = pop_s ? mem_r[head_r].addr : 5'd0;
    assign RegData  = pop_s ? mem_r[head_r].data : 32'd0;
    assign Count    = count_r;
    assign Empty    = empty_s;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        valid_s  = '0;
        offset_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_s   = PTR_W'(i) - head_r;
            valid_s[i] = ({1'b0, offset_s} < count_r);
        end
    end

    // Head/tail pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; a register-0 request completes the handshake but is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_r <= '0;
        end else if (push_s) begin
            mem_r[tail_r] <= '{addr: WrAddr, data: WrData};
        end
    end

    gpr_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
        .entries (mem_r),
        .valid   (valid_s),
        .tail    (tail_r),
        .addr    (Rs),
        .hit     (RsHit),
        .data    (RsFwd)
    );

    gpr_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
        .entries (mem_r),
        .valid   (valid_s),
        .tail    (tail_r),
        .addr    (Rt),
        .hit     (RtHit),
        .data    (RtFwd)
    );

endmodule

// File: tb/tb_gpr_write_queue.sv
// Randomized and directed bench for gpr_write_queue against a queue-based reference model.
module tb_gpr_write_queue;
    import gpr_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        WrValid;
    logic        WrReady;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        Stall;
    logic        RegWrite;
    logic [4:0]  RegAddr;
    logic [31:0] RegData;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic        RsHit;
    logic        RtHit;
    logic [31:0] RsFwd;
    logic [31:0] RtFwd;
    logic [2:0]  Count;
    logic        Empty;

    gpr_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .WrValid(WrValid), .WrReady(WrReady),
        .WrAddr(WrAddr), .WrData(WrData), .Stall(Stall), .RegWrite(RegWrite),
        .RegAddr(RegAddr), .RegData(RegData), .Rs(Rs), .Rt(Rt),
        .RsHit(RsHit), .RtHit(RtHit), .RsFwd(RsFwd), .RtFwd(RtFwd),
        .Count(Count), .Empty(Empty)
    );

    always #5 clk = ~clk;

    gpr_wr_t model_q[$];
    int      tests_run    = 0;
    int      tests_failed = 0;
    int      issued       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Youngest queued value for a register, searched from the tail back.
    task automatic model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (a != 5'd0) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (!h && model_q[i].addr == a) begin
                    h = 1'b1;
                    d = model_q[i].data;
                end
            end
        end
    endtask

    task automatic check_outputs(output logic exp_ready, output logic exp_write);
        logic        h;
        logic [31:0] d;
        exp_ready = reset && (model_q.size() < DEPTH);
        exp_write = (model_q.size() > 0) && !Stall;
        check("count",    32'(Count),    32'(model_q.size()));
        check("empty",    32'(Empty),    32'(model_q.size() == 0));
        check("wr_ready", 32'(WrReady),  32'(exp_ready));
        check("reg_write", 32'(RegWrite), 32'(exp_write));
        check("reg_addr", 32'(RegAddr),  exp_write ? 32'(model_q[0].addr) : 32'd0);
        check("reg_data", RegData,       exp_write ? model_q[0].data : 32'd0);
        model_lookup(Rs, h, d);
        check("rs_hit", 32'(RsHit), 32'(h));
        check("rs_fwd", RsFwd, d);
        model_lookup(Rt, h, d);
        check("rt_hit", 32'(RtHit), 32'(h));
        check("rt_fwd", RtFwd, d);
    endtask

    // One clock: drive at posedge+1, check before the edge, advance the model at the edge.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic st, input logic [4:0] rs, input logic [4:0] rt,
                         output logic acc);
        logic     exp_ready;
        logic     exp_write;
        gpr_wr_t  e;
        WrValid = v; WrAddr = a; WrData = d; Stall = st; Rs = rs; Rt = rt;
        #3;
        check_outputs(exp_ready, exp_write);
        @(posedge clk);
        acc = v && exp_ready;
        if (exp_write) begin
            void'(model_q.pop_front());
            issued++;
        end
        if (acc && a != 5'd0) begin
            e.addr = a;
            e.data = d;
            model_q.push_back(e);
        end
        #1;
    endtask

    logic        acc;
    logic        pend;
    logic [4:0]  p_addr;
    logic [31:0] p_data;

    initial begin
        reset = 1'b0; WrValid = 1'b0; WrAddr = 5'd0; WrData = 32'd0;
        Stall = 1'b0; Rs = 5'd0; Rt = 5'd0;
        #2;
        check("rst_ready", 32'(WrReady), 32'd0);
        check("rst_empty", 32'(Empty), 32'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;

        // Single write then drain.
        cycle(1'b1, 5'd8, 32'h1234_5678, 1'b0, 5'd8, 5'd0, acc);
        check("single_acc", 32'(acc), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd0, acc);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd0, acc);

        // Register-0 drop.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, acc);
        check("zero_acc", 32'(acc), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, acc);

        // Stall fill then ordered drain.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 5'(i), 32'(i * 17), 1'b1, 5'(i), 5'd0, acc);
        end
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd4, acc);
        check("full_ready", 32'(WrReady), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd2, 5'd4, acc);
        end

        // Forwarding priority.
        cycle(1'b1, 5'd5, 32'hA, 1'b1, 5'd0, 5'd0, acc);
        cycle(1'b1, 5'd6, 32'hB, 1'b1, 5'd0, 5'd0, acc);
        cycle(1'b1, 5'd5, 32'hC, 1'b1, 5'd0, 5'd0, acc);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6, acc);
        check("fwd_rs_c", RsFwd, 32'hC);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd6, acc);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd6, acc);
        end

        // Randomized traffic with handshake-stable requests and stall pulses.
        pend = 1'b0; p_addr = 5'd0; p_data = 32'd0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && ($urandom % 3) != 0) begin
                pend   = 1'b1;
                p_addr = 5'($urandom % 8);
                p_data = $urandom;
            end
            cycle(pend, p_addr, p_data, ($urandom % 4) == 0,
                  5'($urandom % 8), 5'($urandom % 8), acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, acc);
        end

        // Asynchronous reset with three pending entries.
        cycle(1'b1, 5'd1, 32'h111, 1'b1, 5'd0, 5'd0, acc);
        cycle(1'b1, 5'd2, 32'h222, 1'b1, 5'd0, 5'd0, acc);
        cycle(1'b1, 5'd3, 32'h333, 1'b1, 5'd0, 5'd0, acc);
        WrValid = 1'b0; Stall = 1'b0; Rs = 5'd1; Rt = 5'd2;
        #2;
        check("pre_rst_count", 32'(Count), 32'd3);
        reset = 1'b0;
        #1;
        model_q.delete();
        check("arst_write", 32'(RegWrite), 32'd0);
        check("arst_addr",  32'(RegAddr), 32'd0);
        check("arst_data",  RegData, 32'd0);
        check("arst_rshit", 32'(RsHit), 32'd0);
        check("arst_rthit", 32'(RtHit), 32'd0);
        check("arst_rsfwd", RsFwd, 32'd0);
        check("arst_rtfwd", RtFwd, 32'd0);
        check("arst_count", 32'(Count), 32'd0);
        check("arst_empty", 32'(Empty), 32'd1);
        check("arst_ready", 32'(WrReady), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rel_ready", 32'(WrReady), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd3, acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gpr_write_queue.md
# gpr_write_queue

Buffered write-side initiator for the general-purpose register file. It accepts register write requests from the datapath over a valid/ready handshake and holds them in a DEPTH-entry in-order queue. It issues them one per cycle onto the register file write port (RegWrite/RegAddr/RegData). It also answers Rs/Rt forwarding lookups against pending writes, so that reads of a register with a queued write return the youngest queued value.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- WrValid  in  1  producer has a write request
- WrReady  out  1  queue can accept; equals !full, and 0 while reset is asserted
- WrAddr  in  5  destination register
- WrData  in  32  write data
- Stall  in  1  register file write port unavailable this cycle
- RegWrite  out  1  write strobe to the register file
- RegAddr  out  5  write address to the register file
- RegData  out  32  write data to the register file
- Rs  in  5  lookup address A
- Rt  in  5  lookup address B
- RsHit  out  1  pending write targets Rs
- RtHit  out  1  pending write targets Rt
- RsFwd  out  32  youngest pending data for Rs, else 0
- RtFwd  out  32  youngest pending data for Rt, else 0
- Count  out  $clog2(DEPTH)+1  current occupancy
- Empty  out  1  Count == 0

## Operation
- Handshake: a request transfers on a rising edge with WrValid && WrReady. WrAddr/WrData are sampled at that edge. The producer holds WrValid/WrAddr/WrData stable until the transfer.
- Register 0: an accepted request with WrAddr == 0 completes the handshake but is not stored. Count is unchanged.
- Issue: RegWrite = !Empty && !Stall. RegAddr and RegData are the head entry when RegWrite = 1, else 0. The head pops on any edge where RegWrite = 1.
- Simultaneous push and pop: Count is unchanged and both pointers advance. A push with no pop increments Count; a pop with no push decrements it.
- Full: WrReady = 0 even if a pop occurs in the same cycle. There is no full-bypass.
- Pointers wrap modulo DEPTH. Count saturates structurally at DEPTH.
- Forwarding is combinational over all valid entries, head included. It selects the youngest match, nearest the tail.
  - Rs == 0 forces RsHit = 0 and RsFwd = 0. The same rule applies to Rt.
  - The WrValid request of the current cycle is not searched.
- Reset (asynchronous): pointers and Count are set to 0 and all pending entries are discarded, including in mid-burst. Outputs while in reset: RegWrite = 0, RegAddr = 0, RegData = 0, RsHit = RtHit = 0, RsFwd = RtFwd = 0, Count = 0, Empty = 1, WrReady = 0.

## Timing
- Enqueue-to-issue latency: a request accepted at edge N appears on RegWrite in cycle N+1 if Stall = 0. The register file commits it at edge N+1.
- Throughput: one accept and one issue per cycle. With Stall held at 0, occupancy under a continuous stream stays at 1.
- Stall for k cycles holds the head entry for k cycles. The queue fills after DEPTH accepts.
- Forwarding outputs reflect the queue state after the most recent edge. A hit on the head entry remains valid in the cycle it issues, because the register file holds that value after the edge.
- After reset deasserts, WrReady rises combinationally and the first accept can occur at the next edge.

## Structure
- Shared package gpr_pkg holds:
  - REG_W = 5, DATA_W = 32
  - REG_ZERO = 5'd0, REG_RA = 5'd31
  - struct gpr_wr_t {addr, data}, reused by the register file side.
- Sub-module gpr_fwd_match, instantiated twice (Rs and Rt): takes the entry array, valid mask, tail pointer and lookup address, and returns hit and data using a youngest-first priority search.
- Storage is an array of gpr_wr_t plus head/tail pointers and Count. No separate valid bits are needed; validity is derived from head and Count.

## Test plan
- Reset then single write: push (8, 0x1234_5678). Next cycle: RegWrite = 1, RegAddr = 8, RegData = 0x12345678. The cycle after: Empty = 1.
- Zero drop: push (0, 0xFFFF_FFFF). Required: the handshake completes, Count stays 0, and RegWrite never asserts.
- Stall fill, DEPTH = 4: Stall = 1, push (1, 0x11), (2, 0x22), (3, 0x33), (4, 0x44). Required: WrReady = 0 after the fourth push. Release Stall: four issues in order, one per cycle, with values 0x11..0x44.
- Forwarding priority: Stall = 1, push (5, 0xA), (6, 0xB), (5, 0xC); set Rs = 5, Rt = 6. Required: RsHit = 1 with RsFwd = 0xC; RtHit = 1 with RtFwd = 0xB. With Rs = 0: RsHit = 0 and RsFwd = 0.
- Wrap-around: run 10 push/pop pairs with interleaved Stall pulses. Required: issue order equals push order, and Count matches the bench model at every edge.
- Reset mid-operation: three pending entries, then reset = 0 asynchronously between edges. Required: outputs go immediately to their reset values. After reset is released, Empty = 1 and no stale entry issues.
